// File: rtl/panic_hdr_fork_pkg.sv
// Shared constants and helpers for the RX header fork.
// The header span is shared with the downstream header parser.
package panic_hdr_fork_pkg;

    localparam int PANIC_HDR_BYTES = 38;
    localparam int POP_W = 64;

    function automatic logic [7:0] popcount(
        input logic [POP_W-1:0] v
    );
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/panic_hdr_fork_ctrl.sv
// Two-output stream fork with per-output sent flags.
// Output b is optional per beat (b_need); output a always takes the beat.
module axis_fork_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic s_valid,
    output logic s_ready,
    output logic a_valid,
    input  logic a_ready,
    input  logic b_need,
    output logic b_valid,
    input  logic b_ready,
    output logic b_stall,
    output logic accept
);

    logic a_sent;
    logic b_sent;
    logic a_done;
    logic b_done;

    assign a_done  = a_sent | a_ready;
    assign b_done  = !b_need | b_sent | b_ready;
    assign a_valid = !rst & s_valid & !a_sent;
    assign b_valid = !rst & s_valid & b_need & !b_sent;
    assign s_ready = !rst & a_done & b_done;
    assign accept  = s_valid & s_ready;
    assign b_stall = b_valid & !b_ready & a_done;

    // A side that already took the beat must not see it again
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sent <= 1'b0;
            b_sent <= 1'b0;
        end else if (accept) begin
            a_sent <= 1'b0;
            b_sent <= 1'b0;
        end else begin
            if (a_valid && a_ready) a_sent <= 1'b1;
            if (b_valid && b_ready) b_sent <= 1'b1;
        end
    end

endmodule

// File: rtl/panic_hdr_fork.sv
// RX front end: forks ingress into a full packet stream and a
// header-only stream for the parser, with packet/runt statistics.
module panic_hdr_fork
    import panic_hdr_fork_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_BYTES  = PANIC_HDR_BYTES,
    parameter int HDR_BEATS  = (HDR_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_pkt_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_pkt_axis_tkeep,
    output logic                  m_pkt_axis_tvalid,
    output logic                  m_pkt_axis_tlast,
    input  logic                  m_pkt_axis_tready,
    output logic [DATA_WIDTH-1:0] m_hdr_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_hdr_axis_tkeep,
    output logic                  m_hdr_axis_tvalid,
    output logic                  m_hdr_axis_tlast,
    input  logic                  m_hdr_axis_tready,
    output logic [CNT_WIDTH-1:0]  stat_pkt_count,
    output logic [CNT_WIDTH-1:0]  stat_runt_count,
    output logic                  stat_hdr_stall
);

    localparam int BW = $clog2(HDR_BEATS + 1);

    logic [BW-1:0] beat_idx;
    logic [15:0]   byte_acc;
    logic [15:0]   byte_sum;
    logic          hdr_need;
    logic          accept;

    assign hdr_need = int'(beat_idx) < HDR_BEATS;
    assign byte_sum = byte_acc
        + 16'(popcount(POP_W'(s_axis_tkeep)));

    assign m_pkt_axis_tdata = s_axis_tdata;
    assign m_pkt_axis_tkeep = s_axis_tkeep;
    assign m_pkt_axis_tlast = s_axis_tlast;
    assign m_hdr_axis_tdata = s_axis_tdata;
    assign m_hdr_axis_tkeep = s_axis_tkeep;
    assign m_hdr_axis_tlast = s_axis_tlast
        | (int'(beat_idx) == HDR_BEATS - 1);

    axis_fork_ctrl u_fork (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .a_valid (m_pkt_axis_tvalid),
        .a_ready (m_pkt_axis_tready),
        .b_need  (hdr_need),
        .b_valid (m_hdr_axis_tvalid),
        .b_ready (m_hdr_axis_tready),
        .b_stall (stat_hdr_stall),
        .accept  (accept)
    );

    // byte_acc saturates at the header span; only "short or not" matters
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx        <= '0;
            byte_acc        <= '0;
            stat_pkt_count  <= '0;
            stat_runt_count <= '0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                beat_idx       <= '0;
                byte_acc       <= '0;
                stat_pkt_count <= stat_pkt_count + 1'b1;
                if (byte_sum < 16'(HDR_BYTES)) begin
                    stat_runt_count <= stat_runt_count + 1'b1;
                end
            end else begin
                if (hdr_need) beat_idx <= beat_idx + 1'b1;
                byte_acc <= (byte_sum >= 16'(HDR_BYTES))
                    ? 16'(HDR_BYTES) : byte_sum;
            end
        end
    end

endmodule

// File: tb/tb_panic_hdr_fork.sv
// Directed bench for panic_hdr_fork with a two-path scoreboard.
module tb_panic_hdr_fork;

    localparam int DW = 256;
    localparam int KW = 32;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] p_tdata;
    logic [KW-1:0] p_tkeep;
    logic          p_tvalid;
    logic          p_tlast;
    logic          p_tready = 1'b1;
    logic [DW-1:0] h_tdata;
    logic [KW-1:0] h_tkeep;
    logic          h_tvalid;
    logic          h_tlast;
    logic          h_tready = 1'b1;
    logic [31:0]   pkt_cnt;
    logic [31:0]   runt_cnt;
    logic          hdr_stall;

    beat_t pkt_q[$];
    beat_t hdr_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pkt_hs = 0;
    int    hdr_hs = 0;
    int    tb_idx = 0;

    always #5 clk = ~clk;

    panic_hdr_fork dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tdata      (s_tdata),
        .s_axis_tkeep      (s_tkeep),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .m_pkt_axis_tdata  (p_tdata),
        .m_pkt_axis_tkeep  (p_tkeep),
        .m_pkt_axis_tvalid (p_tvalid),
        .m_pkt_axis_tlast  (p_tlast),
        .m_pkt_axis_tready (p_tready),
        .m_hdr_axis_tdata  (h_tdata),
        .m_hdr_axis_tkeep  (h_tkeep),
        .m_hdr_axis_tvalid (h_tvalid),
        .m_hdr_axis_tlast  (h_tlast),
        .m_hdr_axis_tready (h_tready),
        .stat_pkt_count    (pkt_cnt),
        .stat_runt_count   (runt_cnt),
        .stat_hdr_stall    (hdr_stall)
    );

    task automatic check(
        input string        tag,
        input logic [288:0] obs,
        input logic [288:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        beat_t e;
        if (p_tvalid && p_tready) begin
            pkt_hs++;
            check("pkt_q_nonempty",
                  289'(pkt_q.size() != 0), 289'(1));
            if (pkt_q.size() != 0) begin
                e = pkt_q.pop_front();
                check("pkt_beat", {p_tlast, p_tkeep, p_tdata}, e);
            end
        end
        if (h_tvalid && h_tready) begin
            hdr_hs++;
            check("hdr_q_nonempty",
                  289'(hdr_q.size() != 0), 289'(1));
            if (hdr_q.size() != 0) begin
                e = hdr_q.pop_front();
                check("hdr_beat", {h_tlast, h_tkeep, h_tdata}, e);
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [KW-1:0] keep_of(input int n);
        logic [KW-1:0] one;
        one = 1;
        return (n >= KW) ? '1 : (one << n) - 1'b1;
    endfunction

    task automatic expect_beat(
        input logic [DW-1:0] d,
        input logic [KW-1:0] k,
        input logic          l
    );
        pkt_q.push_back('{l, k, d});
        if (tb_idx < 2) hdr_q.push_back('{l | (tb_idx == 1), k, d});
        tb_idx = l ? 0 : ((tb_idx < 2) ? tb_idx + 1 : 2);
    endtask

    task automatic send_beat(
        input  logic [DW-1:0] d,
        input  logic [KW-1:0] k,
        input  logic          l,
        input  bit            rnd,
        output int            cyc
    );
        logic acc;
        expect_beat(d, k, l);
        @(negedge clk);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        acc = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            if (i > 0) @(negedge clk);
            if (rnd) begin
                p_tready = 1'($urandom_range(0, 1));
                h_tready = 1'($urandom_range(0, 1));
            end
            #1;
            acc = s_tready;
            cyc++;
            @(posedge clk);
        end
        #1 s_tvalid = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: observed=0 expected=1");
            $display("Result: errors=%0d of %0d checks",
                     errors, checks);
            $fatal(1, "accept timeout");
        end
    endtask

    task automatic send_pkt(input int len, input bit rnd);
        int nb;
        int cyc;
        nb = (len + KW - 1) / KW;
        for (int b = 0; b < nb; b++) begin
            send_beat(rnd_data(),
                      keep_of(len - b * KW),
                      b == nb - 1, rnd, cyc);
        end
    endtask

    initial begin
        int cyc;
        int p0;
        int h0;
        int n_rand;
        int n_runt;
        int len;
        logic [DW-1:0] d0;

        // Reset: valids and ready held low even with input valid
        s_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pkt_valid", 289'(p_tvalid), 289'(0));
        check("rst_hdr_valid", 289'(h_tvalid), 289'(0));
        check("rst_s_ready", 289'(s_tready), 289'(0));
        check("rst_pkt_cnt", 289'(pkt_cnt), 289'(0));
        check("rst_runt_cnt", 289'(runt_cnt), 289'(0));
        s_tvalid = 1'b0;
        rst = 1'b0;

        // 64-byte packet, both ready
        send_pkt(64, 1'b0);
        check("t1_pkt_cnt", 289'(pkt_cnt), 289'(1));
        check("t1_runt_cnt", 289'(runt_cnt), 289'(0));

        // 128-byte packet; header path not ready on beats 2-3
        p0 = pkt_hs;
        h0 = hdr_hs;
        for (int b = 0; b < 4; b++) begin
            h_tready = (b < 2);
            send_beat(rnd_data(), '1, b == 3, 1'b0, cyc);
            if (b >= 2) check("t2_ready_no_hdr", 289'(cyc), 289'(1));
        end
        h_tready = 1'b1;
        check("t2_pkt_beats", 289'(pkt_hs - p0), 289'(4));
        check("t2_hdr_beats", 289'(hdr_hs - h0), 289'(2));
        check("t2_pkt_cnt", 289'(pkt_cnt), 289'(2));

        // Header path stalls 3 cycles on beat 0
        p0 = pkt_hs;
        d0 = rnd_data();
        expect_beat(d0, '1, 1'b0);
        @(negedge clk);
        h_tready = 1'b0;
        s_tdata  = d0;
        s_tkeep  = '1;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("t3_stall", 289'(hdr_stall), 289'(1));
            check("t3_s_ready", 289'(s_tready), 289'(0));
            if (c > 0) check("t3_pkt_valid", 289'(p_tvalid), 289'(0));
            @(posedge clk);
        end
        @(negedge clk);
        h_tready = 1'b1;
        #1;
        check("t3_accept", 289'(s_tready), 289'(1));
        check("t3_no_stall", 289'(hdr_stall), 289'(0));
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        check("t3_pkt_once", 289'(pkt_hs - p0), 289'(1));
        send_beat(rnd_data(), '1, 1'b1, 1'b0, cyc);
        check("t3_pkt_cnt", 289'(pkt_cnt), 289'(3));

        // 20-byte single-beat runt
        send_beat(rnd_data(), 32'h000F_FFFF, 1'b1, 1'b0, cyc);
        check("t4_pkt_cnt", 289'(pkt_cnt), 289'(4));
        check("t4_runt_cnt", 289'(runt_cnt), 289'(1));

        // Runt boundary: exactly 38 bytes is not a runt, 37 is
        send_pkt(38, 1'b0);
        check("t5_38_runt", 289'(runt_cnt), 289'(1));
        send_pkt(37, 1'b0);
        check("t5_37_runt", 289'(runt_cnt), 289'(2));
        check("t5_pkt_cnt", 289'(pkt_cnt), 289'(6));

        // Random lengths with random backpressure on both outputs
        n_rand = 150;
        n_runt = 0;
        for (int p = 0; p < n_rand; p++) begin
            len = $urandom_range(14, 1514);
            if (len < 38) n_runt++;
            send_pkt(len, 1'b1);
        end
        p_tready = 1'b1;
        h_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_pkt_cnt", 289'(pkt_cnt), 289'(6 + n_rand));
        check("t6_runt_cnt", 289'(runt_cnt), 289'(2 + n_runt));
        check("t6_pkt_drained", 289'(pkt_q.size()), 289'(0));
        check("t6_hdr_drained", 289'(hdr_q.size()), 289'(0));

        // Reset after beat 1 of a 4-beat packet
        send_beat(rnd_data(), '1, 1'b0, 1'b0, cyc);
        send_beat(rnd_data(), '1, 1'b0, 1'b0, cyc);
        @(negedge clk);
        rst = 1'b1;
        s_tdata  = rnd_data();
        s_tkeep  = '1;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        #1;
        check("t7_pkt_valid", 289'(p_tvalid), 289'(0));
        check("t7_hdr_valid", 289'(h_tvalid), 289'(0));
        check("t7_s_ready", 289'(s_tready), 289'(0));
        @(negedge clk);
        check("t7_pkt_cnt", 289'(pkt_cnt), 289'(0));
        check("t7_runt_cnt", 289'(runt_cnt), 289'(0));
        s_tvalid = 1'b0;
        rst = 1'b0;
        tb_idx = 0;
        send_pkt(64, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t7_sop_pkt_cnt", 289'(pkt_cnt), 289'(1));
        check("t7_pkt_drained", 289'(pkt_q.size()), 289'(0));
        check("t7_hdr_drained", 289'(hdr_q.size()), 289'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
